l1d_entry_alloc_tracker: RTL and testbench
==========================================

Name: l1d_entry_alloc_tracker

Overview:
- Tracks occupancy of an N-entry L1D resource pool (MSHR / line-buffer style) as a registered valid bitmap.
- Grants up to two allocations per cycle, lowest free index first, and retires entries by release mask.
- Feeds the valid bitmap to the downstream population counter for occupancy cross-checking.
- Keeps its own registered occupancy count for flow control: full, empty and almost-full.

Parameters:
- ENTRY_NUM, 8, number of tracked entries; must be at least 2.
- AFULL_THRESH, 6, almost_full_o asserts when occupancy is at least this value; must be ENTRY_NUM or less.
- IDX_W, $clog2(ENTRY_NUM), entry index width; derived, not overridable.
- CNT_W, $clog2(ENTRY_NUM)+1, occupancy count width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  clear all entries at the next edge.
- alloc_req_vld_i  in  2  allocation request per port; port 0 has priority.
- alloc_gnt_o  out  2  combinational grant per port.
- alloc_idx0_o  out  IDX_W  index granted to port 0.
- alloc_idx1_o  out  IDX_W  index granted to port 1.
- release_mask_i  in  ENTRY_NUM  entries to free at the next edge.
- valid_vec_o  out  ENTRY_NUM  registered valid bitmap, for the downstream popcount.
- occ_cnt_o  out  CNT_W  registered occupancy.
- full_o  out  1  occ_cnt_o == ENTRY_NUM.
- empty_o  out  1  occ_cnt_o == 0.
- almost_full_o  out  1  occ_cnt_o >= AFULL_THRESH.
- err_o  out  1  sticky error: release of a non-valid entry.

Behaviour:
- Reset (rst low, asynchronous): valid_vec_o=0, occ_cnt_o=0, err_o=0.
  - Outputs during reset: empty_o=1, full_o=0, almost_full_o=0, alloc_gnt_o=0.
- Free search always uses the registered valid bitmap.
  - f0 = lowest clear bit; f1 = second-lowest clear bit.
- Grants, zero latency:
  - Port 0 is granted f0 if requesting and f0 exists.
  - Port 1 is granted f0 if port 0 is not requesting, else f1.
  - A grant is never given without a free entry.
  - The port-1 grant never depends on release_mask_i.
- alloc_idx*_o is don't-care when not granted; drive 0.
- Entries released this cycle are not allocatable until the following cycle.
- Next state at each edge:
  - valid_next = (valid & ~release_mask_i) | granted one-hot bits.
  - A granted bit can never coincide with a released bit, because a granted entry was not valid.
- occ_cnt next = occ_cnt + popcount(grants) − popcount(release_mask_i & valid). Width CNT_W; never wraps.
- Release of an entry that is not currently valid:
  - That bit is ignored; no count change.
  - err_o sets next cycle and holds until reset.
- flush_i:
  - At the next edge, valid=0 and occ_cnt=0.
  - While flush_i is high, alloc_gnt_o=0: flush overrides alloc and release in the same cycle.
  - Invalid-release errors are not flagged during flush.
- Status decode from registered occ_cnt_o:
  - Full: no grants.
  - One free entry: only one grant, with port-0 priority.
  - Full plus release: grants resume the cycle after the release.
- Invariant every cycle: occ_cnt_o == popcount(valid_vec_o). The bench checks it against the downstream counter.
- Reset mid-operation: all state clears immediately; requests pending in that cycle are lost. The requester must re-issue.

Test Plan:
- Reset with ENTRY_NUM=8, then alloc_req_vld_i=2'b11 for 4 cycles:
  - Grant indices per cycle: (0,1), (2,3), (4,5), (6,7).
  - Afterwards occ_cnt_o=8 and full_o=1; almost_full_o=1 from the cycle occ_cnt_o reaches 6.
- Full pool, release_mask_i=8'h24 with alloc_req_vld_i=2'b11:
  - No grants that cycle.
  - Next cycle: grants idx (2,5), occ_cnt_o back to 8.
- Valid=8'h7F, alloc_req_vld_i=2'b11 -> only port 0 granted idx 7; alloc_gnt_o=2'b01; next full_o=1.
- alloc_req_vld_i=2'b10 on empty pool -> port 1 granted idx 0; valid_vec_o=8'h01 next cycle.
- Valid=8'h0F, release_mask_i=8'h30 -> no count change; err_o=1 next cycle and holds across later valid traffic.
- Valid=8'hFF, flush_i=1 with alloc_req_vld_i=2'b11 and release_mask_i=8'h01:
  - alloc_gnt_o=0 that cycle.
  - Next cycle: valid_vec_o=0, occ_cnt_o=0, empty_o=1.

Source files
------------

// File: rtl/l1d_entry_alloc_tracker_if.sv
// Bundle of the allocate/release/status signals exchanged between an L1D
// requester (master) and the entry allocation tracker (slave).
interface l1d_entry_alloc_tracker_if #(
  parameter int ENTRY_NUM = 8
);
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = $clog2(ENTRY_NUM) + 1;

  logic                 flush_i;
  logic [1:0]           alloc_req_vld_i;
  logic [1:0]           alloc_gnt_o;
  logic [IDX_W-1:0]     alloc_idx0_o;
  logic [IDX_W-1:0]     alloc_idx1_o;
  logic [ENTRY_NUM-1:0] release_mask_i;
  logic [ENTRY_NUM-1:0] valid_vec_o;
  logic [CNT_W-1:0]     occ_cnt_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 almost_full_o;
  logic                 err_o;

  // Requester side: issues allocations, releases and flushes.
  modport master (
    output flush_i, alloc_req_vld_i, release_mask_i,
    input  alloc_gnt_o, alloc_idx0_o, alloc_idx1_o, valid_vec_o,
    input  occ_cnt_o, full_o, empty_o, almost_full_o, err_o
  );

  // Tracker side: answers grants and reports occupancy.
  modport slave (
    input  flush_i, alloc_req_vld_i, release_mask_i,
    output alloc_gnt_o, alloc_idx0_o, alloc_idx1_o, valid_vec_o,
    output occ_cnt_o, full_o, empty_o, almost_full_o, err_o
  );
endinterface

// File: rtl/l1d_entry_alloc_tracker.sv
// L1D entry allocation tracker: registered valid bitmap with two-port
// lowest-free-first allocation, mask-based release, flush, and a registered
// occupancy count driving full / empty / almost-full flow control.
module l1d_entry_alloc_tracker #(
  parameter int ENTRY_NUM    = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  l1d_entry_alloc_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = $clog2(ENTRY_NUM) + 1;

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]     occ_cnt_q, occ_cnt_d;
  logic                 err_q, err_d;

  logic [IDX_W-1:0]     f0, f1;
  logic                 f0_ok, f1_ok;
  logic                 gnt0, gnt1;
  logic [IDX_W-1:0]     idx1_sel;
  logic [ENTRY_NUM-1:0] gnt_onehot;
  logic [ENTRY_NUM-1:0] rel_hit;
  logic [ENTRY_NUM-1:0] rel_bad;
  logic [CNT_W-1:0]     rel_cnt;

  // Lowest and second-lowest free entries, from the registered bitmap only,
  // so an entry released this cycle is not handed out until next cycle.
  always_comb begin
    f0    = '0;
    f1    = '0;
    f0_ok = 1'b0;
    f1_ok = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!valid_q[i]) begin
        if (!f0_ok) begin
          f0_ok = 1'b1;
          f0    = IDX_W'(i);
        end else if (!f1_ok) begin
          f1_ok = 1'b1;
          f1    = IDX_W'(i);
        end
      end
    end
  end

  // Zero-latency grants; port 0 takes f0, port 1 takes whatever is left.
  // Reset and flush both suppress grants; release never influences them.
  always_comb begin
    gnt0     = rst && !bus.flush_i && bus.alloc_req_vld_i[0] && f0_ok;
    gnt1     = rst && !bus.flush_i && bus.alloc_req_vld_i[1] &&
               (bus.alloc_req_vld_i[0] ? f1_ok : f0_ok);
    idx1_sel = bus.alloc_req_vld_i[0] ? f1 : f0;
  end

  // Per-entry decode of grant one-hots and release classification.
  generate
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
      assign gnt_onehot[gi] = (gnt0 && (f0 == IDX_W'(gi))) ||
                              (gnt1 && (idx1_sel == IDX_W'(gi)));
      assign rel_hit[gi]    = bus.release_mask_i[gi] && valid_q[gi];
      assign rel_bad[gi]    = bus.release_mask_i[gi] && !valid_q[gi];
    end
  endgenerate

  // Number of entries actually retired this cycle.
  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      rel_cnt = rel_cnt + CNT_W'(rel_hit[i]);
    end
  end

  // Next-state: flush wins over everything; otherwise retire then allocate.
  // Releases of non-valid entries are dropped but latch the sticky error.
  always_comb begin
    valid_d   = valid_q;
    occ_cnt_d = occ_cnt_q;
    err_d     = err_q;
    if (bus.flush_i) begin
      valid_d   = '0;
      occ_cnt_d = '0;
    end else begin
      valid_d   = (valid_q & ~bus.release_mask_i) | gnt_onehot;
      occ_cnt_d = occ_cnt_q + CNT_W'(gnt0) + CNT_W'(gnt1) - rel_cnt;
      err_d     = err_q | (|rel_bad);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      occ_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      occ_cnt_q <= occ_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.alloc_gnt_o   = {gnt1, gnt0};
  assign bus.alloc_idx0_o  = gnt0 ? f0 : '0;
  assign bus.alloc_idx1_o  = gnt1 ? idx1_sel : '0;
  assign bus.valid_vec_o   = valid_q;
  assign bus.occ_cnt_o     = occ_cnt_q;
  assign bus.err_o         = err_q;
  assign bus.full_o        = (occ_cnt_q == CNT_W'(ENTRY_NUM));
  assign bus.empty_o       = (occ_cnt_q == '0);
  assign bus.almost_full_o = (occ_cnt_q >= CNT_W'(AFULL_THRESH));

endmodule

// File: tb/tb_l1d_entry_alloc_tracker.sv
// Self-checking bench for l1d_entry_alloc_tracker: directed scenarios plus
// randomized traffic against a free-list reference model.
module tb_l1d_entry_alloc_tracker;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l1d_entry_alloc_tracker_if #(.ENTRY_NUM(N)) bus();

  l1d_entry_alloc_tracker #(.ENTRY_NUM(N), .AFULL_THRESH(6)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: set of occupied entries plus sticky error flag.
  bit   [N-1:0] m_valid;
  bit           m_err;
  logic [1:0]   exp_gnt;
  logic [2:0]   exp_i0, exp_i1;
  logic [1:0]   cur_req;
  logic [N-1:0] cur_rel;
  logic         cur_fl;

  // Grants: list the free entries in ascending order and hand them out.
  function automatic void model_grant();
    int free_q[$];
    int k;
    free_q = {};
    for (int i = 0; i < N; i++) if (!m_valid[i]) free_q.push_back(i);
    exp_gnt = 2'b00;
    exp_i0  = 3'd0;
    exp_i1  = 3'd0;
    if (!cur_fl) begin
      if (cur_req[0] && free_q.size() > 0) begin
        exp_gnt[0] = 1'b1;
        exp_i0     = 3'(free_q[0]);
      end
      if (cur_req[1]) begin
        k = cur_req[0] ? 1 : 0;
        if (free_q.size() > k) begin
          exp_gnt[1] = 1'b1;
          exp_i1     = 3'(free_q[k]);
        end
      end
    end
  endfunction

  function automatic void model_commit();
    if (cur_fl) begin
      m_valid = '0;
    end else begin
      if ((cur_rel & ~m_valid) != 0) m_err = 1'b1;
      m_valid = m_valid & ~cur_rel;
      if (exp_gnt[0]) m_valid[exp_i0] = 1'b1;
      if (exp_gnt[1]) m_valid[exp_i1] = 1'b1;
    end
  endfunction

  task automatic apply(input logic [1:0] req, input logic [N-1:0] rel, input logic fl);
    @(negedge clk);
    cur_req = req;
    cur_rel = rel;
    cur_fl  = fl;
    bus.alloc_req_vld_i = req;
    bus.release_mask_i  = rel;
    bus.flush_i         = fl;
    model_grant();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
    $display("txn t=%0t req=%b rel=%h flush=%b exp_gnt=%b idx=(%0d,%0d) valid=%h occ=%0d err=%b",
             $time, cur_req, cur_rel, cur_fl, exp_gnt, exp_i0, exp_i1,
             bus.valid_vec_o, bus.occ_cnt_o, bus.err_o);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cur_req = 2'b11; cur_rel = '0; cur_fl = 1'b0;
    bus.alloc_req_vld_i = 2'b11;
    bus.release_mask_i  = '0;
    bus.flush_i         = 1'b0;
    m_valid = '0;
    m_err   = 1'b0;
    #3;
    total_cnt++; if (bus.valid_vec_o !== 8'h00) $display("FAIL reset_valid: got %h want 00", bus.valid_vec_o); else pass_cnt++;
    total_cnt++; if (bus.occ_cnt_o !== 4'd0) $display("FAIL reset_occ: got %0d want 0", bus.occ_cnt_o); else pass_cnt++;
    total_cnt++; if (bus.err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_o); else pass_cnt++;
    total_cnt++; if (bus.empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty_o); else pass_cnt++;
    total_cnt++; if (bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0) $display("FAIL reset_full_afull: got %b%b want 00", bus.full_o, bus.almost_full_o); else pass_cnt++;
    total_cnt++; if (bus.alloc_gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", bus.alloc_gnt_o); else pass_cnt++;
    bus.alloc_req_vld_i = 2'b00;
    cur_req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [N-1:0] ev;
    for (int k = 0; k < 4; k++) begin
      apply(2'b11, 8'h00, 1'b0);
      total_cnt++; if (bus.alloc_gnt_o !== 2'b11) $display("FAIL fill_gnt%0d: got %b want 11", k, bus.alloc_gnt_o); else pass_cnt++;
      total_cnt++; if (bus.alloc_idx0_o !== 3'(2*k) || bus.alloc_idx1_o !== 3'(2*k+1))
        $display("FAIL fill_idx%0d: got (%0d,%0d) want (%0d,%0d)", k, bus.alloc_idx0_o, bus.alloc_idx1_o, 2*k, 2*k+1); else pass_cnt++;
      tick();
      ev = N'((1 << (2*k+2)) - 1);
      total_cnt++; if (bus.occ_cnt_o !== 4'(2*k+2) || bus.valid_vec_o !== ev)
        $display("FAIL fill_state%0d: got occ=%0d valid=%h want occ=%0d valid=%h", k, bus.occ_cnt_o, bus.valid_vec_o, 2*k+2, ev); else pass_cnt++;
      total_cnt++; if (bus.almost_full_o !== (2*k+2 >= 6)) $display("FAIL fill_afull%0d: got %b want %b", k, bus.almost_full_o, (2*k+2 >= 6)); else pass_cnt++;
    end
    total_cnt++; if (bus.full_o !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.full_o); else pass_cnt++;
  endtask

  task automatic test_full_release();
    apply(2'b11, 8'h24, 1'b0);
    total_cnt++; if (bus.alloc_gnt_o !== 2'b00) $display("FAIL fullrel_gnt: got %b want 00", bus.alloc_gnt_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.occ_cnt_o !== 4'd6 || bus.valid_vec_o !== 8'hDB) $display("FAIL fullrel_state: got occ=%0d valid=%h want occ=6 valid=db", bus.occ_cnt_o, bus.valid_vec_o); else pass_cnt++;
    apply(2'b11, 8'h00, 1'b0);
    total_cnt++; if (bus.alloc_gnt_o !== 2'b11 || bus.alloc_idx0_o !== 3'd2 || bus.alloc_idx1_o !== 3'd5)
      $display("FAIL fullrel_regrant: got gnt=%b idx=(%0d,%0d) want gnt=11 idx=(2,5)", bus.alloc_gnt_o, bus.alloc_idx0_o, bus.alloc_idx1_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.occ_cnt_o !== 4'd8 || bus.full_o !== 1'b1) $display("FAIL fullrel_refull: got occ=%0d full=%b want occ=8 full=1", bus.occ_cnt_o, bus.full_o); else pass_cnt++;
  endtask

  task automatic test_one_free();
    apply(2'b00, 8'h80, 1'b0);
    tick();
    total_cnt++; if (bus.valid_vec_o !== 8'h7F) $display("FAIL onefree_setup: got %h want 7f", bus.valid_vec_o); else pass_cnt++;
    apply(2'b11, 8'h00, 1'b0);
    total_cnt++; if (bus.alloc_gnt_o !== 2'b01 || bus.alloc_idx0_o !== 3'd7)
      $display("FAIL onefree_gnt: got gnt=%b idx0=%0d want gnt=01 idx0=7", bus.alloc_gnt_o, bus.alloc_idx0_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.full_o !== 1'b1) $display("FAIL onefree_full: got %b want 1", bus.full_o); else pass_cnt++;
  endtask

  task automatic test_port1_only();
    apply(2'b00, 8'h00, 1'b1);
    tick();
    total_cnt++; if (bus.empty_o !== 1'b1) $display("FAIL p1_empty: got %b want 1", bus.empty_o); else pass_cnt++;
    apply(2'b10, 8'h00, 1'b0);
    total_cnt++; if (bus.alloc_gnt_o !== 2'b10 || bus.alloc_idx1_o !== 3'd0)
      $display("FAIL p1_gnt: got gnt=%b idx1=%0d want gnt=10 idx1=0", bus.alloc_gnt_o, bus.alloc_idx1_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.valid_vec_o !== 8'h01) $display("FAIL p1_valid: got %h want 01", bus.valid_vec_o); else pass_cnt++;
  endtask

  task automatic test_err();
    apply(2'b11, 8'h00, 1'b0); tick();
    apply(2'b01, 8'h00, 1'b0); tick();
    total_cnt++; if (bus.valid_vec_o !== 8'h0F || bus.err_o !== 1'b0) $display("FAIL err_setup: got valid=%h err=%b want 0f 0", bus.valid_vec_o, bus.err_o); else pass_cnt++;
    apply(2'b00, 8'h30, 1'b0); tick();
    total_cnt++; if (bus.occ_cnt_o !== 4'd4 || bus.valid_vec_o !== 8'h0F) $display("FAIL err_nochange: got occ=%0d valid=%h want 4 0f", bus.occ_cnt_o, bus.valid_vec_o); else pass_cnt++;
    total_cnt++; if (bus.err_o !== 1'b1) $display("FAIL err_set: got %b want 1", bus.err_o); else pass_cnt++;
    apply(2'b01, 8'h01, 1'b0);
    total_cnt++; if (bus.alloc_idx0_o !== 3'd4) $display("FAIL err_relnotfree: got idx0=%0d want 4", bus.alloc_idx0_o); else pass_cnt++;
    tick();
    apply(2'b00, 8'h02, 1'b0); tick();
    total_cnt++; if (bus.valid_vec_o !== 8'h1C || bus.occ_cnt_o !== 4'd3 || bus.err_o !== 1'b1)
      $display("FAIL err_hold: got valid=%h occ=%0d err=%b want 1c 3 1", bus.valid_vec_o, bus.occ_cnt_o, bus.err_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    repeat (3) begin apply(2'b11, 8'h00, 1'b0); tick(); end
    total_cnt++; if (bus.valid_vec_o !== 8'hFF) $display("FAIL flush_setup: got %h want ff", bus.valid_vec_o); else pass_cnt++;
    apply(2'b11, 8'h01, 1'b1);
    total_cnt++; if (bus.alloc_gnt_o !== 2'b00) $display("FAIL flush_gnt: got %b want 00", bus.alloc_gnt_o); else pass_cnt++;
    tick();
    total_cnt++; if (bus.valid_vec_o !== 8'h00 || bus.occ_cnt_o !== 4'd0 || bus.empty_o !== 1'b1)
      $display("FAIL flush_clear: got valid=%h occ=%0d empty=%b want 00 0 1", bus.valid_vec_o, bus.occ_cnt_o, bus.empty_o); else pass_cnt++;
    total_cnt++; if (bus.err_o !== 1'b1) $display("FAIL flush_err_keep: got %b want 1", bus.err_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply(2'b11, 8'h00, 1'b0); tick();
    apply(2'b11, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.valid_vec_o !== 8'h00 || bus.occ_cnt_o !== 4'd0 || bus.err_o !== 1'b0)
      $display("FAIL midrst_clear: got valid=%h occ=%0d err=%b want 00 0 0", bus.valid_vec_o, bus.occ_cnt_o, bus.err_o); else pass_cnt++;
    total_cnt++; if (bus.alloc_gnt_o !== 2'b00) $display("FAIL midrst_gnt: got %b want 00", bus.alloc_gnt_o); else pass_cnt++;
    m_valid = '0;
    m_err   = 1'b0;
    bus.alloc_req_vld_i = 2'b00;
    cur_req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    apply(2'b00, 8'h00, 1'b0); tick();
    total_cnt++; if (bus.empty_o !== 1'b1) $display("FAIL midrst_lost: got empty=%b want 1", bus.empty_o); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [1:0]   req;
    logic [N-1:0] rel;
    logic         fl;
    int           cnt;
    for (int it = 0; it < 400; it++) begin
      req = 2'($urandom_range(0, 3));
      rel = ($urandom_range(0, 11) == 0) ? N'($urandom) : (N'($urandom) & m_valid);
      fl  = ($urandom_range(0, 24) == 0);
      apply(req, rel, fl);
      total_cnt++; if (bus.alloc_gnt_o !== exp_gnt) $display("FAIL rnd_gnt it%0d: got %b want %b", it, bus.alloc_gnt_o, exp_gnt); else pass_cnt++;
      total_cnt++; if (bus.alloc_idx0_o !== exp_i0 || bus.alloc_idx1_o !== exp_i1)
        $display("FAIL rnd_idx it%0d: got (%0d,%0d) want (%0d,%0d)", it, bus.alloc_idx0_o, bus.alloc_idx1_o, exp_i0, exp_i1); else pass_cnt++;
      tick();
      cnt = $countones(m_valid);
      total_cnt++; if (bus.valid_vec_o !== m_valid) $display("FAIL rnd_valid it%0d: got %h want %h", it, bus.valid_vec_o, m_valid); else pass_cnt++;
      total_cnt++; if (bus.occ_cnt_o !== 4'(cnt) || bus.occ_cnt_o !== 4'($countones(bus.valid_vec_o)))
        $display("FAIL rnd_occ it%0d: got %0d want %0d (popcount %0d)", it, bus.occ_cnt_o, cnt, $countones(bus.valid_vec_o)); else pass_cnt++;
      total_cnt++; if (bus.err_o !== m_err) $display("FAIL rnd_err it%0d: got %b want %b", it, bus.err_o, m_err); else pass_cnt++;
      total_cnt++; if (bus.full_o !== (cnt == N) || bus.empty_o !== (cnt == 0) || bus.almost_full_o !== (cnt >= 6))
        $display("FAIL rnd_status it%0d: got f/e/af=%b%b%b for occ %0d", it, bus.full_o, bus.empty_o, bus.almost_full_o, cnt); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_release();
    test_one_free();
    test_port1_only();
    test_err();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
